moving_average_filter_var: RTL and testbench

//  Parametrised moving-sum/average filter for the self-trigger chain. Averages the last N = 2**win_log2

---
 rtl/st_filter_pkg.sv | 50 +++++
 rtl/circ_delay_ram.sv | 35 +++
 rtl/moving_average_filter_var.sv | 173 +++++++++++++++++
 tb/tb_moving_average_filter_var.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/st_filter_pkg.sv
// -----------------------------------------------------------------------------
// st_filter_pkg
// Shared definitions for the self-trigger filter chain: default widths, the
// output alignment latency used by downstream trigger logic, the window FSM
// state type and the round/saturate helpers used by the averaging filter.
// -----------------------------------------------------------------------------
package st_filter_pkg;

    localparam int W_DEF        = 16;
    localparam int MAX_LOG2_DEF = 5;
    // Enabled clock edges from the input register to y / x_delayed.
    localparam int LAT          = 4;

    typedef enum logic {
        WIN_RUN   = 1'b0,
        WIN_FLUSH = 1'b1
    } win_state_t;

    // Arithmetic right shift by sh with round-half-up; sh = 0 passes through.
    function automatic logic signed [63:0] round_shift(
        input logic signed [63:0] v,
        input logic [2:0]         sh
    );
        logic signed [63:0] half;
        if (sh == 3'd0) begin
            return v;
        end
        half = 64'sd1 <<< (sh - 3'd1);
        return (v + half) >>> sh;
    endfunction

    // Clamp v into the signed range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat_to(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/circ_delay_ram.sv
// -----------------------------------------------------------------------------
// circ_delay_ram
// Single-clock circular delay memory, 2**AW words of W bits, read-first: a
// read of the address being written returns the previous contents. Contents
// are never cleared so the array maps onto LUTRAM/BRAM.
// Ports:
//   clk      in   clock
//   ce       in   clock enable for both the write and the registered read
//   wr_addr  in   write address
//   rd_addr  in   read address
//   din      in   write data
//   dout     out  registered read data (old contents on address collision)
// -----------------------------------------------------------------------------
module circ_delay_ram #(
    parameter int W  = 16,
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 ce,
    input  logic [AW-1:0]        wr_addr,
    input  logic [AW-1:0]        rd_addr,
    input  logic signed [W-1:0]  din,
    output logic signed [W-1:0]  dout
);

    logic signed [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (ce) begin
            dout          <= mem[rd_addr];
            mem[wr_addr]  <= din;
        end
    end

endmodule

// File: rtl/moving_average_filter_var.sv
// -----------------------------------------------------------------------------
// moving_average_filter_var
// Run-time selectable moving average over the last N = 2**win_log2 enabled
// samples of one ADC channel. The result is rounded, offset and saturated;
// a copy of the input aligned with y is provided for baseline/trigger logic.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset (registered once inside)
//   enable     in   sample-valid qualifier (registered once inside)
//   x          in   signed input sample
//   win_log2   in   requested window exponent, clamped to MAX_LOG2
//   y          out  rounded average + OFFSET, saturated to W bits
//   x_delayed  out  input sample aligned with y
//   win_full   out  y is the sum of a complete window
// -----------------------------------------------------------------------------
module moving_average_filter_var
    import st_filter_pkg::*;
#(
    parameter int                  W        = W_DEF,
    parameter int                  MAX_LOG2 = MAX_LOG2_DEF,
    parameter logic signed [W-1:0] OFFSET   = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic signed [W-1:0] x,
    input  logic [2:0]          win_log2,
    output logic signed [W-1:0] y,
    output logic signed [W-1:0] x_delayed,
    output logic                win_full
);

    localparam int         AW    = W + MAX_LOG2;
    localparam int         PW    = MAX_LOG2;
    localparam int         FW    = MAX_LOG2 + 1;
    localparam logic [2:0] MAX_L = 3'(MAX_LOG2);

    logic                 reset_reg;
    logic                 enable_reg;
    logic signed [W-1:0]  x_p0;
    logic [2:0]           win_p0;

    win_state_t           state;
    win_state_t           state_next;
    logic [2:0]           win_len;
    logic [2:0]           win_c;
    logic [FW-1:0]        n_new;
    logic [FW-1:0]        fill;
    logic [FW-1:0]        fill_base;
    logic [FW-1:0]        fill_next;
    logic                 old_use;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_addr;

    logic signed [W-1:0]  x_p1, x_p2, x_p3;
    logic signed [W-1:0]  x_old_p1;
    logic                 old_vld_p1;
    logic                 full_p1, full_p2, full_p3;
    logic [2:0]           l_p1, l_p2;

    logic signed [AW-1:0] acc_p2;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] s_p3;
    logic signed [63:0]   sum_off;

    // ---- input registers: control and raw sample ----
    always_ff @(posedge clk) begin
        reset_reg  <= reset;
        enable_reg <= enable;
        x_p0       <= x;
        win_p0     <= win_log2;
    end

    // Window FSM: a changed (clamped) window request restarts the fill.
    // FLUSH marks the sample now in stage 1 as the first of a new window.
    always_comb begin
        win_c      = (win_p0 > MAX_L) ? MAX_L : win_p0;
        state_next = (win_c != win_len) ? WIN_FLUSH : WIN_RUN;
        n_new      = FW'(1) << win_c;
        fill_base  = (state_next == WIN_FLUSH) ? '0 : fill;
        // Subtract the oldest sample only once N samples are already held.
        old_use    = (fill_base == n_new);
        fill_next  = old_use ? fill_base : fill_base + FW'(1);
        rd_addr    = wr_ptr - n_new[PW-1:0];
    end

    circ_delay_ram #(
        .W  (W),
        .AW (PW)
    ) u_ram (
        .clk     (clk),
        .ce      (enable_reg && !reset_reg),
        .wr_addr (wr_ptr),
        .rd_addr (rd_addr),
        .din     (x_p0),
        .dout    (x_old_p1)
    );

    // ---- stage 1: window control, fill count, delay-line access ----
    always_ff @(posedge clk) begin
        if (reset_reg) begin
            state      <= WIN_RUN;
            win_len    <= '0;
            fill       <= '0;
            wr_ptr     <= '0;
            old_vld_p1 <= 1'b0;
            full_p1    <= 1'b0;
            l_p1       <= '0;
            x_p1       <= '0;
        end else if (enable_reg) begin
            state      <= state_next;
            win_len    <= win_c;
            fill       <= fill_next;
            wr_ptr     <= wr_ptr + PW'(1);
            old_vld_p1 <= old_use;
            full_p1    <= (fill_next == n_new);
            l_p1       <= win_c;
            x_p1       <= x_p0;
        end
    end

    always_comb begin
        acc_next = (state == WIN_FLUSH) ? '0 : acc_p2;
        acc_next = acc_next + {{MAX_LOG2{x_p1[W-1]}}, x_p1};
        if (old_vld_p1) begin
            acc_next = acc_next - {{MAX_LOG2{x_old_p1[W-1]}}, x_old_p1};
        end
    end

    // ---- stage 2: running sum ----
    always_ff @(posedge clk) begin
        if (reset_reg) begin
            acc_p2  <= '0;
            full_p2 <= 1'b0;
            l_p2    <= '0;
            x_p2    <= '0;
        end else if (enable_reg) begin
            acc_p2  <= acc_next;
            full_p2 <= full_p1;
            l_p2    <= l_p1;
            x_p2    <= x_p1;
        end
    end

    // ---- stage 3: divide by N with rounding ----
    always_ff @(posedge clk) begin
        if (reset_reg) begin
            s_p3    <= '0;
            full_p3 <= 1'b0;
            x_p3    <= '0;
        end else if (enable_reg) begin
            s_p3    <= AW'(round_shift(64'(acc_p2), l_p2));
            full_p3 <= full_p2;
            x_p3    <= x_p2;
        end
    end

    assign sum_off = 64'(s_p3) + 64'(OFFSET);

    // ---- stage 4: offset, saturation, outputs ----
    always_ff @(posedge clk) begin
        if (reset_reg) begin
            y         <= '0;
            x_delayed <= '0;
            win_full  <= 1'b0;
        end else if (enable_reg) begin
            y         <= W'(sat_to(sum_off, W));
            x_delayed <= x_p3;
            win_full  <= full_p3;
        end
    end

endmodule

// File: tb/tb_moving_average_filter_var.sv
// -----------------------------------------------------------------------------
// tb_moving_average_filter_var
// Scoreboard bench for two filter instances (OFFSET 0 and OFFSET 4) driven by
// the same stream. Stimulus pushes the expected output of each accepted sample;
// a monitor pops on every output update, and otherwise checks hold / reset.
// -----------------------------------------------------------------------------
module tb_moving_average_filter_var;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic signed [15:0] x = '0;
    logic [2:0]         win_log2 = '0;
    logic signed [15:0] y0, y4, xd0, xd4;
    logic               wf0, wf4;

    always #5 clk = ~clk;

    moving_average_filter_var #(.W(16), .MAX_LOG2(5), .OFFSET(16'sd0)) u_off0 (
        .clk(clk), .reset(reset), .enable(enable), .x(x), .win_log2(win_log2),
        .y(y0), .x_delayed(xd0), .win_full(wf0)
    );

    moving_average_filter_var #(.W(16), .MAX_LOG2(5), .OFFSET(16'sd4)) u_off4 (
        .clk(clk), .reset(reset), .enable(enable), .x(x), .win_log2(win_log2),
        .y(y4), .x_delayed(xd4), .win_full(wf4)
    );

    typedef struct {
        int y0;
        int y4;
        int xd;
        bit full;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    bit   mon_on = 1'b0;
    int   ly0 = 0, ly4 = 0, lxd = 0, lf = 0;

    // Bench copies of the registered reset/enable, to know when outputs move.
    logic rr = 1'b1;
    logic er = 1'b0;
    always @(posedge clk) begin
        rr <= reset;
        er <= enable;
    end

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Reference: plain sum over the samples held since the last flush/reset.
    int hist[$];
    int mL = 0;

    function automatic int sat16(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic exp_t model(int xv, int wv);
        int     wc;
        longint sum;
        exp_t   e;
        wc = (wv > 5) ? 5 : wv;
        if (wc != mL) begin
            mL = wc;
            hist.delete();
        end
        hist.push_back(xv);
        if (hist.size() > (1 << mL)) void'(hist.pop_front());
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        if (mL > 0) sum = (sum + (longint'(1) << (mL - 1))) >>> mL;
        e.y0   = sat16(sum);
        e.y4   = sat16(sum + 4);
        e.xd   = xv;
        e.full = (hist.size() == (1 << mL));
        return e;
    endfunction

    task automatic drive(bit en, int xv, int wv);
        @(negedge clk);
        enable   = en;
        x        = 16'(xv);
        win_log2 = 3'(wv);
    endtask

    task automatic send(int xv, int wv);
        exp_t e;
        e = model(xv, wv);
        q.push_back(e);
        drive(1'b1, xv, wv);
    endtask

    task automatic send_h(int xv, int wv, int hy0, int hy4, bit hf);
        exp_t e;
        e = model(xv, wv);
        e.y0   = hy0;
        e.y4   = hy4;
        e.full = hf;
        q.push_back(e);
        drive(1'b1, xv, wv);
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 12345, int'(win_log2));
    endtask

    // After reset the first three output updates carry the zeroed pipeline.
    task automatic do_reset(int hold);
        exp_t f;
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        q.delete();
        hist.delete();
        mL = 0;
        f.y0 = 0; f.y4 = 4; f.xd = 0; f.full = 1'b0;
        repeat (3) q.push_back(f);
        repeat (hold) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor
    initial begin
        exp_t e;
        bit   fire;
        bit   rst_e;
        forever begin
            @(posedge clk);
            fire  = er && !rr;
            rst_e = rr;
            #1;
            if (mon_on) begin
                if (rst_e) begin
                    chk("rst_y_off0", int'(y0), 0);
                    chk("rst_y_off4", int'(y4), 0);
                    chk("rst_xdel", int'(xd0), 0);
                    chk("rst_full", int'(wf0), 0);
                    ly0 = 0; ly4 = 0; lxd = 0; lf = 0;
                end else if (fire) begin
                    if (q.size() == 0) begin
                        chk("scoreboard_nonempty", q.size(), 1);
                    end else begin
                        e = q.pop_front();
                        chk("y_off0", int'(y0), e.y0);
                        chk("y_off4", int'(y4), e.y4);
                        chk("xdel_off0", int'(xd0), e.xd);
                        chk("xdel_off4", int'(xd4), e.xd);
                        chk("full_off0", int'(wf0), int'(e.full));
                        chk("full_off4", int'(wf4), int'(e.full));
                        ly0 = e.y0; ly4 = e.y4; lxd = e.xd; lf = int'(e.full);
                    end
                end else begin
                    chk("hold_y_off0", int'(y0), ly0);
                    chk("hold_y_off4", int'(y4), ly4);
                    chk("hold_xdel", int'(xd0), lxd);
                    chk("hold_full", int'(wf0), lf);
                end
            end
        end
    end

    // Stimulus
    initial begin
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        do_reset(2);

        // 1: full 32-sample window ramp with constant input
        repeat (40) send(100, 5);

        // 2: single impulse through an 8-sample window
        send_h(32000, 3, 4000, 4004, 1'b0);
        for (int k = 2; k <= 8; k++) send_h(0, 3, 4000, 4004, k == 8);
        repeat (6) send_h(0, 3, 0, 4, 1'b1);

        // 3: rounding with a 2-sample window
        send_h(-3, 1, -1, 3, 1'b0);
        repeat (3) send_h(-3, 1, -3, 1, 1'b1);
        send_h(1, 1, -1, 3, 1'b1);
        for (int k = 0; k < 6; k++) send_h((k % 2 == 0) ? 0 : 1, 1, 1, 5, 1'b1);

        // 4: enable toggled every other cycle
        do_reset(2);
        for (int k = 0; k < 36; k++) begin
            send(100, 5);
            idle(1);
        end

        // 5: mid-stream shrink to 4 samples, then an over-range request
        repeat (6) send(500, 2);
        repeat (34) send(500, 7);

        // 6: single-sample window, saturation with offset, reset mid-stream
        send_h(32767, 0, 32767, 32767, 1'b1);
        send_h(-32768, 0, -32768, -32764, 1'b1);
        send_h(1234, 0, 1234, 1238, 1'b1);
        repeat (3) send_h(0, 0, 0, 4, 1'b1);
        do_reset(3);
        send_h(7, 0, 7, 11, 1'b1);
        send_h(8, 2, 2, 6, 1'b0);
        send_h(8, 2, 4, 8, 1'b0);
        send_h(8, 2, 6, 10, 1'b0);
        send_h(8, 2, 8, 12, 1'b1);

        repeat (3) send(0, 2);
        idle(4);
        chk("in_flight", q.size(), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
